// File: rtl/axis_rate_meter_pkg.sv
// rtl/axis_rate_meter_pkg.sv - FSM state, counter width bounds and saturating add for axis_rate_meter
package axis_rate_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CNT_W_MIN = 16;
  localparam int CNT_W_MAX = 48;

  // Adds in CNT_W_MAX+1 bits and clamps to the all-ones value of a 'width'-bit counter.
  function automatic logic [CNT_W_MAX-1:0] sat_add(input logic [CNT_W_MAX-1:0] a,
                                                   input logic [CNT_W_MAX-1:0] b,
                                                   input int width);
    logic [CNT_W_MAX:0] sum;
    logic [CNT_W_MAX:0] lim;
    lim = ((CNT_W_MAX+1)'(1) << width) - (CNT_W_MAX+1)'(1);
    sum = {1'b0, a} + {1'b0, b};
    sat_add = (sum > lim) ? lim[CNT_W_MAX-1:0] : sum[CNT_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/axis_rate_meter_popcnt.sv
// rtl/axis_rate_meter_popcnt.sv - combinational population count of a tkeep vector
module axis_rate_meter_popcnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/axis_rate_meter.sv
// rtl/axis_rate_meter.sv - passive AXI-Stream beat/byte/frame/stall meter over a cycle window
// Define AXIS_RATE_METER_FRAME_EN to build the tlast frame counter.
module axis_rate_meter
  import axis_rate_meter_pkg::*;
#(
  parameter int KEEP_ENABLE = 1,
  parameter int KEEP_WIDTH  = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEEP_WIDTH-1:0] mon_axis_tkeep,
  input  logic                  mon_axis_tvalid,
  input  logic                  mon_axis_tready,
  input  logic                  mon_axis_tlast,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  window_len,
  input  logic [7:0]            rate_num,
  input  logic [7:0]            rate_denom,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  byte_count,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic                  result_valid,
  output logic                  over_rate
);

  localparam int POP_W  = $clog2(KEEP_WIDTH + 1);
  localparam int SAT_W  = (CNT_WIDTH < CNT_W_MIN) ? CNT_W_MIN :
                          (CNT_WIDTH > CNT_W_MAX) ? CNT_W_MAX : CNT_WIDTH;
  localparam int PROD_W = CNT_WIDTH + 8;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] win_len_q, win_len_d, win_cnt_q, win_cnt_d;
  logic [CNT_WIDTH-1:0] beat_acc_q, beat_acc_d, byte_acc_q, byte_acc_d, stall_acc_q, stall_acc_d;
  logic [CNT_WIDTH-1:0] beat_snap_q, byte_snap_q, stall_snap_q;
  logic                 result_valid_q, over_rate_q;
  logic [POP_W-1:0]     keep_pop;
  logic [CNT_WIDTH-1:0] byte_inc, beat_sum, byte_sum, stall_sum;
  logic [PROD_W-1:0]    lhs, rhs;
  logic                 beat, stall, start, count_en, win_end, acc_clr, over_calc;

  axis_rate_meter_popcnt #(
    .WIDTH (KEEP_WIDTH),
    .CNT_W (POP_W)
  ) u_popcnt (
    .bits_i  (mon_axis_tkeep),
    .count_o (keep_pop)
  );

  assign beat     = mon_axis_tvalid & mon_axis_tready;
  assign stall    = mon_axis_tvalid & ~mon_axis_tready;
  assign byte_inc = !beat ? '0 :
                    (KEEP_ENABLE != 0) ? CNT_WIDTH'(keep_pop) : CNT_WIDTH'(KEEP_WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable && window_len != '0) state_d = ST_RUN;
      ST_RUN:  if (!enable || (win_end && window_len == '0)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start    = (state_q == ST_IDLE) && enable && (window_len != '0);
    count_en = (state_q == ST_RUN) && enable;
    win_end  = count_en && (win_cnt_q == win_len_q - CNT_WIDTH'(1));
    acc_clr  = !count_en || win_end;
  end

  // Sums include this cycle's events so a window-end snapshot sees its final cycle.
  always_comb begin
    beat_sum  = CNT_WIDTH'(sat_add(CNT_W_MAX'(beat_acc_q), CNT_W_MAX'(beat), SAT_W));
    byte_sum  = CNT_WIDTH'(sat_add(CNT_W_MAX'(byte_acc_q), CNT_W_MAX'(byte_inc), SAT_W));
    stall_sum = CNT_WIDTH'(sat_add(CNT_W_MAX'(stall_acc_q), CNT_W_MAX'(stall), SAT_W));
    lhs       = PROD_W'(beat_sum) * PROD_W'(rate_denom);
    rhs       = PROD_W'(rate_num) * PROD_W'(win_len_q);
    over_calc = (rate_denom != 8'd0) && (lhs > rhs);
    beat_acc_d  = acc_clr ? '0 : beat_sum;
    byte_acc_d  = acc_clr ? '0 : byte_sum;
    stall_acc_d = acc_clr ? '0 : stall_sum;
    win_cnt_d   = acc_clr ? '0 : win_cnt_q + CNT_WIDTH'(1);
    win_len_d   = win_len_q;
    if (start || (win_end && window_len != '0)) win_len_d = window_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len_q      <= '0;
      win_cnt_q      <= '0;
      beat_acc_q     <= '0;
      byte_acc_q     <= '0;
      stall_acc_q    <= '0;
      beat_snap_q    <= '0;
      byte_snap_q    <= '0;
      stall_snap_q   <= '0;
      result_valid_q <= 1'b0;
      over_rate_q    <= 1'b0;
    end else begin
      win_len_q      <= win_len_d;
      win_cnt_q      <= win_cnt_d;
      beat_acc_q     <= beat_acc_d;
      byte_acc_q     <= byte_acc_d;
      stall_acc_q    <= stall_acc_d;
      result_valid_q <= win_end;
      if (win_end) begin
        beat_snap_q  <= beat_sum;
        byte_snap_q  <= byte_sum;
        stall_snap_q <= stall_sum;
        over_rate_q  <= over_calc;
      end
    end
  end

`ifdef AXIS_RATE_METER_FRAME_EN
  logic [CNT_WIDTH-1:0] frame_acc_q, frame_acc_d, frame_snap_q, frame_sum;

  assign frame_sum   = CNT_WIDTH'(sat_add(CNT_W_MAX'(frame_acc_q), CNT_W_MAX'(beat & mon_axis_tlast), SAT_W));
  assign frame_acc_d = acc_clr ? '0 : frame_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_acc_q  <= '0;
      frame_snap_q <= '0;
    end else begin
      frame_acc_q <= frame_acc_d;
      if (win_end) frame_snap_q <= frame_sum;
    end
  end

  assign frame_count = frame_snap_q;
`else
  logic unused_tlast;
  assign unused_tlast = mon_axis_tlast;
  assign frame_count  = '0;
`endif

  assign beat_count   = beat_snap_q;
  assign byte_count   = byte_snap_q;
  assign stall_count  = stall_snap_q;
  assign result_valid = result_valid_q;
  assign over_rate    = over_rate_q;

endmodule

// File: tb/tb_axis_rate_meter.sv
// tb/tb_axis_rate_meter.sv - randomized self-checking bench for axis_rate_meter against a window-list model
module tb_axis_rate_meter;

  localparam int KW  = 8;
  localparam int CW  = 32;
  localparam int CW2 = 16;
`ifdef AXIS_RATE_METER_FRAME_EN
  localparam bit FRAME_ON = 1'b1;
`else
  localparam bit FRAME_ON = 1'b0;
`endif
  localparam longint unsigned MAXC = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] tkeep = '0;
  logic          tvalid = 1'b0, tready = 1'b0, tlast = 1'b0, enable = 1'b0;
  logic [CW-1:0] window_len = '0;
  logic [7:0]    rate_num = '0, rate_denom = '0;
  logic [CW-1:0] beat_count, byte_count, frame_count, stall_count;
  logic          result_valid, over_rate;

  logic           enable2 = 1'b0;
  logic [CW2-1:0] window_len2 = '0;
  logic [CW2-1:0] beat2, byte2, frame2, stall2;
  logic           rv2, or2;

  always #5 clk = ~clk;

  axis_rate_meter #(.KEEP_ENABLE(1), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .mon_axis_tkeep(tkeep), .mon_axis_tvalid(tvalid),
    .mon_axis_tready(tready), .mon_axis_tlast(tlast), .enable(enable), .window_len(window_len),
    .rate_num(rate_num), .rate_denom(rate_denom), .beat_count(beat_count), .byte_count(byte_count),
    .frame_count(frame_count), .stall_count(stall_count), .result_valid(result_valid),
    .over_rate(over_rate)
  );

  axis_rate_meter #(.KEEP_ENABLE(1), .KEEP_WIDTH(KW), .CNT_WIDTH(CW2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .mon_axis_tkeep(tkeep), .mon_axis_tvalid(tvalid),
    .mon_axis_tready(tready), .mon_axis_tlast(tlast), .enable(enable2), .window_len(window_len2),
    .rate_num(rate_num), .rate_denom(rate_denom), .beat_count(beat2), .byte_count(byte2),
    .frame_count(frame2), .stall_count(stall2), .result_valid(rv2), .over_rate(or2)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a window is simply the list of its cycles' events; totals are summed when it is full.
  typedef struct {
    bit beat;
    int bytes;
    bit last;
    bit stall;
  } ev_t;

  ev_t             q[$];
  bit              m_run = 1'b0;
  longint unsigned m_len = 0;
  longint unsigned e_beat = 0, e_byte = 0, e_frame = 0, e_stall = 0;
  bit              e_valid = 1'b0, e_over = 1'b0;

  function automatic longint unsigned clampc(input longint unsigned v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_run = 1'b0; m_len = 0;
    e_beat = 0; e_byte = 0; e_frame = 0; e_stall = 0; e_valid = 1'b0; e_over = 1'b0;
  endtask

  task automatic model_edge();
    ev_t ev;
    longint unsigned sb, sby, sf, ss;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_valid = 1'b0;
    if (!m_run) begin
      if (enable && window_len != 0) begin
        m_run = 1'b1; m_len = window_len; q.delete();
      end
    end else if (!enable) begin
      m_run = 1'b0; q.delete();
    end else begin
      ev.beat  = tvalid && tready;
      ev.bytes = ev.beat ? $countones(tkeep) : 0;
      ev.last  = ev.beat && tlast;
      ev.stall = tvalid && !tready;
      q.push_back(ev);
      if (q.size() == m_len) begin
        sb = 0; sby = 0; sf = 0; ss = 0;
        foreach (q[i]) begin
          sb += q[i].beat; sby += q[i].bytes; sf += q[i].last; ss += q[i].stall;
        end
        e_beat  = clampc(sb);
        e_byte  = clampc(sby);
        e_frame = FRAME_ON ? clampc(sf) : 0;
        e_stall = clampc(ss);
        e_over  = (rate_denom != 0) && (e_beat * rate_denom > rate_num * m_len);
        e_valid = 1'b1;
        q.delete();
        if (window_len != 0) m_len = window_len;
        else m_run = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("valid", result_valid, e_valid);
    check("beat", beat_count, e_beat);
    check("byte", byte_count, e_byte);
    check("frame", frame_count, e_frame);
    check("stall", stall_count, e_stall);
    check("over", over_rate, e_over);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic go_idle();
    enable = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;

    // continuous full beats, window of 10
    tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF; window_len = 10; enable = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 11 || c == 21) begin
        check("p1_pulse", result_valid, 1);
        check("p1_beat", beat_count, 10);
        check("p1_byte", byte_count, 80);
        check("p1_stall", stall_count, 0);
      end
    end
    go_idle();

    // alternating tready, over-rate bound 1/4
    window_len = 8; rate_num = 8'd1; rate_denom = 8'd4; enable = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tready = (c % 2 == 0);
      step();
    end
    check("p2_beat", beat_count, 4);
    check("p2_stall", stall_count, 4);
    check("p2_over", over_rate, 1);
    go_idle();

    // 3-beat frames in a 9-cycle window
    tready = 1'b1; window_len = 9; rate_denom = 8'd0; enable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tlast = (c >= 2) && ((c - 2) % 3 == 2);
      step();
    end
    check("p3_frame", frame_count, FRAME_ON ? 3 : 0);
    check("p3_beat", beat_count, 9);
    tlast = 1'b0;
    go_idle();

    // drop enable mid-window, then a fresh full window
    window_len = 10; enable = 1'b1;
    repeat (6) step();
    enable = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("drop_novalid", result_valid, 0);
      check("drop_beat_kept", beat_count, 9);
    end
    enable = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 10) check("reen_nopulse", result_valid, 0);
    end
    check("reen_pulse", result_valid, 1);
    check("reen_beat", beat_count, 10);
    go_idle();

    // window_len = 1: every run cycle is a window end
    window_len = 1; enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tvalid = 1'($urandom_range(0, 1)); tready = 1'($urandom_range(0, 1));
      step();
      if (c >= 2) check("wl1_valid", result_valid, 1);
    end

    // random traffic, window lengths, rates and enable drops
    window_len = 7;
    for (int c = 0; c < 3000; c++) begin
      tvalid = 1'($urandom_range(0, 3) != 0);
      tready = 1'($urandom_range(0, 2) != 0);
      tkeep  = 8'($urandom);
      tlast  = 1'($urandom_range(0, 3) == 0);
      rate_num   = 8'($urandom_range(0, 12));
      rate_denom = 8'($urandom_range(0, 16));
      if ($urandom_range(0, 19) == 0) window_len = $urandom_range(0, 12);
      enable = ($urandom_range(0, 39) != 0);
      step();
    end
    go_idle();

    // asynchronous reset in the middle of a window
    tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF; window_len = 10; enable = 1'b1;
    repeat (13) step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    enable = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    window_len = 3; enable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) check("rst_nopulse", result_valid, 0);
    end
    check("rst_new_win", result_valid, 1);
    check("rst_new_beat", beat_count, 3);
    go_idle();

    // 16-bit instance: byte count clamps at all-ones
    tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF; window_len2 = 16'd10000; enable2 = 1'b1;
    for (int c = 1; c <= 10001; c++) begin
      step();
      if (c == 10000) check("sat_nopulse", rv2, 0);
    end
    check("sat_pulse", rv2, 1);
    check("sat_byte", byte2, 16'hFFFF);
    check("sat_beat", beat2, 16'd10000);
    check("sat_stall", stall2, 0);
    enable2 = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_rate_meter.md
# axis_rate_meter

Passive AXI4-Stream throughput monitor; the measuring counterpart of the stream rate limiter. Taps one stream's handshake signals, gathers beats, bytes, frames and stall cycles over a programmable window of clock cycles, and publishes a registered snapshot at every window end. It also flags when the measured beat rate exceeds a num/denom bound, which lets software confirm that limiter settings hold at the point of use. It never drives the monitored stream.

## Interface
- KEEP_ENABLE, (DATA_WIDTH>8) of tapped stream, default 1: use tkeep for byte counting; if 0, every beat counts KEEP_WIDTH bytes.
- KEEP_WIDTH, 8: tkeep width, 1..64.
- CNT_WIDTH, 32: width of every counter and snapshot, 16..48.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mon_axis_tkeep  in  KEEP_WIDTH  tapped tkeep.
- mon_axis_tvalid  in  1  tapped tvalid.
- mon_axis_tready  in  1  tapped tready.
- mon_axis_tlast  in  1  tapped tlast.
- enable  in  1  run the meter.
- window_len  in  CNT_WIDTH  window length in cycles; 0 means idle.
- rate_num  in  8  allowed beats per rate_denom cycles.
- rate_denom  in  8  rate denominator; 0 disables the over-rate check.
- beat_count  out  CNT_WIDTH  beats in the last window.
- byte_count  out  CNT_WIDTH  bytes in the last window.
- frame_count  out  CNT_WIDTH  tlast beats in the last window.
- stall_count  out  CNT_WIDTH  cycles with tvalid && !tready.
- result_valid  out  1  one-cycle pulse when a new snapshot is loaded.
- over_rate  out  1  last window satisfied beat_count*rate_denom > rate_num*window_len.

## Operation
- Beat means tvalid && tready in the same cycle. Bytes per beat = popcount(tkeep), or KEEP_WIDTH when KEEP_ENABLE=0.
- States:
  - IDLE: counters held at 0. Go to RUN when enable=1 and window_len≠0. At that transition, latch window_len into win_len_reg and clear win_cnt.
  - RUN: win_cnt increments each cycle and the accumulators add the current cycle's events. On the cycle where win_cnt == win_len_reg-1:
    - load accumulator values plus this cycle's events into the snapshots;
    - compute and load over_rate;
    - clear the accumulators and win_cnt;
    - re-latch window_len if it is ≠0, otherwise return to IDLE.
  - enable=0 in RUN: return to IDLE next cycle and discard partial counts. Snapshots and over_rate keep their last values. No result_valid pulse.
- Accumulators saturate at all-ones and never wrap.
- over_rate compare: unsigned, computed in CNT_WIDTH+8 bits on the saturated beat count and the latched window length. Forced to 0 when rate_denom=0.
- rate_num and rate_denom are sampled on the window-end cycle only.

## Timing
- Reset clears all outputs and internal state to 0; FSM starts in IDLE.
- Snapshot latency: an event in the final window cycle appears in the snapshot at the next clk edge. result_valid is high for exactly that following cycle.
- Consecutive windows have no gaps. Window k+1 counts from the cycle immediately after window k's final cycle.
- window_len=1: every RUN cycle is a window end and result_valid is high continuously.
- Asserting rst_n low mid-window clears everything immediately and emits no partial snapshot.
- Monitor inputs are sampled only and have no combinational path to outputs.

## Configuration
- AXIS_RATE_METER_FRAME_EN defined: frame counting is built; frame_count counts beats with tlast=1.
- Not defined: the frame accumulator is not instantiated, frame_count is tied to 0, and mon_axis_tlast is ignored.

## Structure
- Package axis_rate_meter_pkg holds:
  - the FSM state enum (IDLE, RUN);
  - the CNT_WIDTH bounds constants;
  - a saturating-add function.
- One sub-module, axis_rate_meter_popcnt: combinational tkeep popcount. It is the only natural split; all counters stay in the top module.

## Test plan
- window_len=10, continuous beats, tkeep=8'hFF for 25 cycles → first two snapshots: beat=10, byte=80, stall=0; result_valid pulses at cycles 11 and 21 after enable.
- window_len=8, tvalid=1 with tready alternating 1/0 → beat=4, stall=4. With rate_num=1 and rate_denom=4, over_rate=1 (4*4 > 1*8).
- Frames of 3 beats with tlast on beat 3, window_len=9, macro defined → frame_count=3. Same stimulus with the macro undefined → frame_count=0.
- CNT_WIDTH=16, window_len=16'hFFFF, KEEP_WIDTH=8, all-ones tkeep → byte_count saturates at 16'hFFFF and never wraps.
- Drop enable at cycle 5 of a 10-cycle window → no result_valid pulse and snapshots unchanged. Re-enable → a fresh full window.
- Assert rst_n low mid-window → all outputs 0 immediately. Release → meter in IDLE, and a new window starts one cycle after enable=1.
